// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 timing constants and helpers shared by the sync generator.
package vga_timing_pkg;
    localparam int CNT_W = 10;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    function automatic int timing_total(input int disp, input int front,
                                        input int sync, input int back);
        return disp + front + sync + back;
    endfunction
endpackage

// File: rtl/vga_sync_delay_line.sv
// Generic WIDTH x DEPTH enabled shift register with a per-bit reset value.
module sync_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [DEPTH-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= {DEPTH{RST_VAL}};
        end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++)
                stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];
endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-tick divider, h/v counters, delayed syncs and blanked color.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int PIPE_DLY  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] color_in,
    output logic        pixel_tick,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        video_on,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb
);
    localparam int H_TOTAL  = timing_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL  = timing_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] h, v;
    logic             h_wrap, v_wrap;
    logic             hs_raw, vs_raw, vid_d;
    logic [11:0]      color_q;

    // Tick is registered from the terminal count, so with CLK_DIV=1 it is high every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            pixel_tick <= 1'b0;
        end else begin
            pixel_tick <= (div_cnt == DIV_LAST);
            div_cnt    <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    assign h_wrap = (h == H_LAST);
    assign v_wrap = (v == V_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h           <= '0;
            v           <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pixel_tick && h_wrap && v_wrap;
            if (pixel_tick) begin
                if (h_wrap) begin
                    h <= '0;
                    v <= v_wrap ? '0 : v + 1'b1;
                end else begin
                    h <= h + 1'b1;
                end
            end
        end
    end

    assign pixel_x  = h;
    assign pixel_y  = v;
    assign video_on = (h < CNT_W'(H_DISPLAY)) && (v < CNT_W'(V_DISPLAY));
    assign hs_raw   = !((h >= CNT_W'(HS_START)) && (h < CNT_W'(HS_END)));
    assign vs_raw   = !((v >= CNT_W'(VS_START)) && (v < CNT_W'(VS_END)));

    // Idle state of the pipe: syncs deasserted (high), video off.
    sync_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (3'b110)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .en  (pixel_tick),
        .d   ({hs_raw, vs_raw, video_on}),
        .q   ({hsync, vsync, vid_d})
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             color_q <= '0;
        else if (pixel_tick) color_q <= color_in;
    end

    assign rgb = vid_d ? color_q : 12'h000;
endmodule
